// File: rtl/vga_bounce_box_if.sv
// Pixel-stream bundle between VGA_Counter/VGA_Sync and the bounce-box pattern stage.
// The pattern stage is the slave: it takes counts and pause, and returns RGB plus the frame tick.
interface vga_bounce_box_if #(
    parameter int COLOR_BITS = 3
) ();
    logic [9:0]            i_Col_Count;
    logic [9:0]            i_Row_Count;
    logic                  i_Pause;
    logic [COLOR_BITS-1:0] o_Red_Video;
    logic [COLOR_BITS-1:0] o_Grn_Video;
    logic [COLOR_BITS-1:0] o_Blu_Video;
    logic                  o_Frame_Tick;

    modport slave (
        input  i_Col_Count, i_Row_Count, i_Pause,
        output o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Tick
    );

    modport master (
        output i_Col_Count, i_Row_Count, i_Pause,
        input  o_Red_Video, o_Grn_Video, o_Blu_Video, o_Frame_Tick
    );
endinterface

// File: rtl/vga_bounce_box.sv
// Draws one solid box that moves once per FRAME_DIV frames, bounces off the active-area edges
// and steps through a 7-colour cycle on each bounce. RGB is registered with one cycle of latency.
module vga_bounce_box #(
    parameter int COLOR_BITS  = 3,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int BOX_W       = 20,
    parameter int BOX_H       = 100,
    parameter int START_X     = 50,
    parameter int START_Y     = 50,
    parameter int STEP        = 2,
    parameter int FRAME_DIV   = 1
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    vga_bounce_box_if.slave  bus
);
    localparam int MAX_X = ACTIVE_COLS - BOX_W;
    localparam int MAX_Y = ACTIVE_ROWS - BOX_H;
    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [9:0]            x_q, x_d, y_q, y_d;
    logic                  dir_x_q, dir_x_d;   // 1 = right
    logic                  dir_y_q, dir_y_d;   // 1 = down
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic                  tick_q;
    logic                  bounce_x_s, bounce_y_s;
    logic                  hit_s;
    logic [10:0]           x_ext_s, y_ext_s, col_ext_s, row_ext_s;
    logic [COLOR_BITS-1:0] red_q, grn_q, blu_q;

    assign x_ext_s   = {1'b0, x_q};
    assign y_ext_s   = {1'b0, y_q};
    assign col_ext_s = {1'b0, bus.i_Col_Count};
    assign row_ext_s = {1'b0, bus.i_Row_Count};

    // Next position, direction, divider and colour; only a non-paused tick can change them.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        frame_cnt_d = frame_cnt_q;
        idx_d       = idx_q;
        bounce_x_s  = 1'b0;
        bounce_y_s  = 1'b0;
        if (tick_q && !bus.i_Pause) begin
            if (frame_cnt_q == CNT_W'(FRAME_DIV - 1)) begin
                frame_cnt_d = {CNT_W{1'b0}};
                if (dir_x_q) begin
                    if (x_ext_s + 11'(STEP) >= 11'(MAX_X)) begin
                        x_d        = 10'(MAX_X);
                        dir_x_d    = 1'b0;
                        bounce_x_s = 1'b1;
                    end else begin
                        x_d = x_q + 10'(STEP);
                    end
                end else begin
                    if (x_ext_s <= 11'(STEP)) begin
                        x_d        = 10'd0;
                        dir_x_d    = 1'b1;
                        bounce_x_s = 1'b1;
                    end else begin
                        x_d = x_q - 10'(STEP);
                    end
                end
                if (dir_y_q) begin
                    if (y_ext_s + 11'(STEP) >= 11'(MAX_Y)) begin
                        y_d        = 10'(MAX_Y);
                        dir_y_d    = 1'b0;
                        bounce_y_s = 1'b1;
                    end else begin
                        y_d = y_q + 10'(STEP);
                    end
                end else begin
                    if (y_ext_s <= 11'(STEP)) begin
                        y_d        = 10'd0;
                        dir_y_d    = 1'b1;
                        bounce_y_s = 1'b1;
                    end else begin
                        y_d = y_q - 10'(STEP);
                    end
                end
                // A corner hit still advances the colour only once; index 0 (black) is skipped.
                if (bounce_x_s || bounce_y_s) begin
                    idx_d = (idx_q == 3'd1) ? 3'd7 : (idx_q - 3'd1);
                end else begin
                    idx_d = idx_q;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Box hit for the current counts, restricted to the visible area.
    always_comb begin
        hit_s = (col_ext_s < 11'(ACTIVE_COLS)) && (row_ext_s < 11'(ACTIVE_ROWS)) &&
                (col_ext_s >= x_ext_s) && (col_ext_s < x_ext_s + 11'(BOX_W)) &&
                (row_ext_s >= y_ext_s) && (row_ext_s < y_ext_s + 11'(BOX_H));
    end

    // Motion state, frame tick and registered pixel output.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            x_q         <= 10'(START_X);
            y_q         <= 10'(START_Y);
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            frame_cnt_q <= {CNT_W{1'b0}};
            idx_q       <= 3'd7;
            tick_q      <= 1'b0;
            red_q       <= {COLOR_BITS{1'b0}};
            grn_q       <= {COLOR_BITS{1'b0}};
            blu_q       <= {COLOR_BITS{1'b0}};
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            frame_cnt_q <= frame_cnt_d;
            idx_q       <= idx_d;
            tick_q      <= (bus.i_Col_Count == 10'd0) && (bus.i_Row_Count == 10'(ACTIVE_ROWS));
            red_q       <= hit_s ? {COLOR_BITS{idx_q[2]}} : {COLOR_BITS{1'b0}};
            grn_q       <= hit_s ? {COLOR_BITS{idx_q[1]}} : {COLOR_BITS{1'b0}};
            blu_q       <= hit_s ? {COLOR_BITS{idx_q[0]}} : {COLOR_BITS{1'b0}};
        end
    end

    assign bus.o_Red_Video  = red_q;
    assign bus.o_Grn_Video  = grn_q;
    assign bus.o_Blu_Video  = blu_q;
    assign bus.o_Frame_Tick = tick_q;
endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box: a default instance plus a corner-start instance
// and a FRAME_DIV=3 instance, all fed the same count stream with separate pause inputs.
module tb_vga_bounce_box;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;

    localparam logic [8:0] WHITE = 9'h1FF;
    localparam logic [8:0] BLACK = 9'h000;
    localparam logic [8:0] C6    = 9'h1F8;
    localparam logic [8:0] C5    = 9'h1C7;

    always #5 clk = ~clk;

    vga_bounce_box_if #(.COLOR_BITS(3)) bm ();
    vga_bounce_box_if #(.COLOR_BITS(3)) bc ();
    vga_bounce_box_if #(.COLOR_BITS(3)) bd ();

    vga_bounce_box dut_m (.i_Clk(clk), .i_Reset(rst), .bus(bm));
    vga_bounce_box #(.START_X(619), .START_Y(379)) dut_c (.i_Clk(clk), .i_Reset(rst), .bus(bc));
    vga_bounce_box #(.FRAME_DIV(3)) dut_d (.i_Clk(clk), .i_Reset(rst), .bus(bd));

    logic [8:0] rgb_m, rgb_c, rgb_d;
    assign rgb_m = {bm.o_Red_Video, bm.o_Grn_Video, bm.o_Blu_Video};
    assign rgb_c = {bc.o_Red_Video, bc.o_Grn_Video, bc.o_Blu_Video};
    assign rgb_d = {bd.o_Red_Video, bd.o_Grn_Video, bd.o_Blu_Video};

    task automatic drive_cycle(input int col, input int row);
        bm.i_Col_Count = 10'(col); bm.i_Row_Count = 10'(row);
        bc.i_Col_Count = 10'(col); bc.i_Row_Count = 10'(row);
        bd.i_Col_Count = 10'(col); bd.i_Row_Count = 10'(row);
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        drive_cycle(0, 480);
        drive_cycle(0, 481);
    endtask

    task automatic test_reset();
        drive_cycle(0, 0);
        drive_cycle(60, 60);
        n_chk++;
        if (rgb_m !== BLACK || bm.o_Frame_Tick !== 1'b0)
            $display("FAIL reset_state rgb=%h tick=%b exp rgb=%h tick=0", rgb_m, bm.o_Frame_Tick, BLACK);
        else n_pass++;
        rst = 1'b0;
        drive_cycle(60, 60);
        n_chk++;
        if (rgb_m !== WHITE) $display("FAIL pre_reset_pixel rgb=%h exp %h", rgb_m, WHITE);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (rgb_m !== BLACK || bm.o_Frame_Tick !== 1'b0)
            $display("FAIL midframe_reset rgb=%h tick=%b exp rgb=%h tick=0", rgb_m, bm.o_Frame_Tick, BLACK);
        else n_pass++;
        drive_cycle(0, 0);
        rst = 1'b0;
    endtask

    task automatic test_pixel();
        drive_cycle(50, 50);
        n_chk++;
        if (rgb_m !== WHITE) $display("FAIL pix_50_50 rgb=%h exp %h", rgb_m, WHITE); else n_pass++;
        drive_cycle(70, 50);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL pix_70_50 rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
        drive_cycle(49, 50);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL pix_49_50 rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
        drive_cycle(69, 149);
        n_chk++;
        if (rgb_m !== WHITE) $display("FAIL pix_69_149 rgb=%h exp %h", rgb_m, WHITE); else n_pass++;
        drive_cycle(69, 150);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL pix_69_150 rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
    endtask

    task automatic test_frame_tick();
        drive_cycle(0, 480);
        n_chk++;
        if (bm.o_Frame_Tick !== 1'b1) $display("FAIL tick_high tick=%b exp 1", bm.o_Frame_Tick); else n_pass++;
        drive_cycle(0, 481);
        n_chk++;
        if (bm.o_Frame_Tick !== 1'b0) $display("FAIL tick_low tick=%b exp 0", bm.o_Frame_Tick); else n_pass++;
        drive_cycle(52, 52);
        n_chk++;
        if (rgb_m !== WHITE) $display("FAIL moved_52_52 rgb=%h exp %h", rgb_m, WHITE); else n_pass++;
        drive_cycle(51, 52);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL moved_51_52 rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
    endtask

    // 284 ticks from start: X=618 right, Y bounced at tick 165 (idx 6) and is now 142 going up.
    task automatic test_bounce_x();
        for (int i = 0; i < 283; i++) do_tick();
        drive_cycle(618, 142);
        n_chk++;
        if (rgb_m !== C6) $display("FAIL x618_before rgb=%h exp %h", rgb_m, C6); else n_pass++;
        drive_cycle(638, 142);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL x638_before rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
        do_tick();
        drive_cycle(620, 140);
        n_chk++;
        if (rgb_m !== C5) $display("FAIL x620_bounce rgb=%h exp %h", rgb_m, C5); else n_pass++;
        drive_cycle(619, 140);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL x619_bounce rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
        do_tick();
        drive_cycle(618, 138);
        n_chk++;
        if (rgb_m !== C5) $display("FAIL x618_after rgb=%h exp %h", rgb_m, C5); else n_pass++;
        drive_cycle(617, 138);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL x617_after rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
    endtask

    task automatic test_pause();
        bm.i_Pause = 1'b1;
        for (int i = 0; i < 3; i++) do_tick();
        drive_cycle(618, 138);
        n_chk++;
        if (rgb_m !== C5) $display("FAIL pause_drawn rgb=%h exp %h", rgb_m, C5); else n_pass++;
        drive_cycle(617, 138);
        n_chk++;
        if (rgb_m !== BLACK) $display("FAIL pause_left rgb=%h exp %h", rgb_m, BLACK); else n_pass++;
        bm.i_Pause = 1'b0;
        do_tick();
        drive_cycle(616, 136);
        n_chk++;
        if (rgb_m !== C5) $display("FAIL unpause_move rgb=%h exp %h", rgb_m, C5); else n_pass++;
        bm.i_Pause = 1'b1;
    endtask

    task automatic test_corner();
        drive_cycle(619, 379);
        n_chk++;
        if (rgb_c !== WHITE) $display("FAIL corner_start rgb=%h exp %h", rgb_c, WHITE); else n_pass++;
        bc.i_Pause = 1'b0;
        do_tick();
        drive_cycle(620, 380);
        n_chk++;
        if (rgb_c !== C6) $display("FAIL corner_hit rgb=%h exp %h", rgb_c, C6); else n_pass++;
        drive_cycle(619, 380);
        n_chk++;
        if (rgb_c !== BLACK) $display("FAIL corner_left rgb=%h exp %h", rgb_c, BLACK); else n_pass++;
        drive_cycle(620, 379);
        n_chk++;
        if (rgb_c !== BLACK) $display("FAIL corner_top rgb=%h exp %h", rgb_c, BLACK); else n_pass++;
        do_tick();
        drive_cycle(618, 378);
        n_chk++;
        if (rgb_c !== C6) $display("FAIL corner_after rgb=%h exp %h", rgb_c, C6); else n_pass++;
        bc.i_Pause = 1'b1;
    endtask

    task automatic test_frame_div();
        bd.i_Pause = 1'b0;
        do_tick();
        drive_cycle(50, 50);
        n_chk++;
        if (rgb_d !== WHITE) $display("FAIL div_tick1 rgb=%h exp %h", rgb_d, WHITE); else n_pass++;
        bd.i_Pause = 1'b1;
        for (int i = 0; i < 3; i++) do_tick();
        bd.i_Pause = 1'b0;
        do_tick();
        drive_cycle(50, 50);
        n_chk++;
        if (rgb_d !== WHITE) $display("FAIL div_tick2 rgb=%h exp %h", rgb_d, WHITE); else n_pass++;
        do_tick();
        drive_cycle(52, 52);
        n_chk++;
        if (rgb_d !== WHITE) $display("FAIL div_tick3 rgb=%h exp %h", rgb_d, WHITE); else n_pass++;
        drive_cycle(50, 50);
        n_chk++;
        if (rgb_d !== BLACK) $display("FAIL div_old_pos rgb=%h exp %h", rgb_d, BLACK); else n_pass++;
    endtask

    initial begin
        bm.i_Pause = 1'b0;
        bc.i_Pause = 1'b1;
        bd.i_Pause = 1'b1;
        test_reset();
        test_pixel();
        test_frame_tick();
        test_bounce_x();
        test_pause();
        test_corner();
        test_frame_div();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
